// File: rtl/wb_shared_bus_arbiter.sv
// Two-master, N-slave shared Wishbone classic interconnect with round-robin ownership,
// address decode and a bus-error generator for unmapped addresses and stalled slaves.
module wb_shared_bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 8,
  parameter int unsigned N_SLAVES       = 4,
  parameter logic [N_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_BASE_ADDRS = 32'h20_10_09_00,
  parameter logic [N_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_HIGH_ADDRS = 32'h3F_1F_09_08,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wbm0_cyc_i,
  input  logic                             wbm0_stb_i,
  input  logic                             wbm0_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]      wbm0_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]        wbm0_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]        wbm0_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]        wbm0_dat_o,
  output logic                             wbm0_ack_o,
  output logic                             wbm0_err_o,
  input  logic                             wbm1_cyc_i,
  input  logic                             wbm1_stb_i,
  input  logic                             wbm1_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]      wbm1_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]        wbm1_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]        wbm1_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]        wbm1_dat_o,
  output logic                             wbm1_ack_o,
  output logic                             wbm1_err_o,
  output logic [N_SLAVES-1:0]              wbs_cyc_o,
  output logic [N_SLAVES-1:0]              wbs_stb_o,
  output logic                             wbs_we_o,
  output logic [BUS_DATA_WIDTH/8-1:0]      wbs_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0]        wbs_adr_o,
  output logic [BUS_DATA_WIDTH-1:0]        wbs_dat_o,
  input  logic [N_SLAVES*BUS_DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [N_SLAVES-1:0]              wbs_ack_i,
  input  logic [N_SLAVES-1:0]              wbs_err_i,
  output logic [1:0]                       grant_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_pending_q, err_pending_d;

  logic                        own0, own1, own_any;
  logic                        m_cyc, m_stb, m_we;
  logic [BUS_DATA_WIDTH/8-1:0] m_sel;
  logic [BUS_ADDR_WIDTH-1:0]   m_adr;
  logic [BUS_DATA_WIDTH-1:0]   m_dat;
  logic [N_SLAVES-1:0]         sel_slave;
  logic                        hit_any;
  logic [BUS_DATA_WIDTH-1:0]   slv_dat;
  logic                        slv_ack, slv_err;
  logic                        m_ack, m_err;
  logic                        keep, stall;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      tmo_cnt_q     <= 8'd0;
      err_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      err_pending_q <= err_pending_d;
    end
  end

  // Ownership is masked during reset so every output is quiet in the reset cycle itself.
  assign own0    = (state_q == StOwn0) && !wb_rst_i;
  assign own1    = (state_q == StOwn1) && !wb_rst_i;
  assign own_any = own0 || own1;

  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_sel = '0;
    m_adr = '0;
    m_dat = '0;
    if (own0) begin
      m_cyc = wbm0_cyc_i;
      m_stb = wbm0_stb_i;
      m_we  = wbm0_we_i;
      m_sel = wbm0_sel_i;
      m_adr = wbm0_adr_i;
      m_dat = wbm0_dat_i;
    end else if (own1) begin
      m_cyc = wbm1_cyc_i;
      m_stb = wbm1_stb_i;
      m_we  = wbm1_we_i;
      m_sel = wbm1_sel_i;
      m_adr = wbm1_adr_i;
      m_dat = wbm1_dat_i;
    end
  end

  // Lowest-index matching range wins when ranges overlap.
  always_comb begin
    sel_slave = '0;
    hit_any   = 1'b0;
    slv_dat   = '0;
    slv_ack   = 1'b0;
    slv_err   = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit_any && own_any &&
          m_adr >= SLAVE_BASE_ADDRS[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH] &&
          m_adr <= SLAVE_HIGH_ADDRS[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]) begin
        sel_slave[i] = 1'b1;
        hit_any      = 1'b1;
        slv_dat      = wbs_dat_i[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        slv_ack      = wbs_ack_i[i];
        slv_err      = wbs_err_i[i];
      end
    end
  end

  assign m_ack = slv_ack && m_stb;
  assign m_err = ((slv_err && m_stb) || (err_pending_q && own_any)) && !m_ack;

  assign wbs_cyc_o = {N_SLAVES{m_cyc}} & sel_slave;
  assign wbs_stb_o = {N_SLAVES{m_stb && !err_pending_q}} & sel_slave;
  assign wbs_we_o  = m_we;
  assign wbs_sel_o = m_sel;
  assign wbs_adr_o = m_adr;
  assign wbs_dat_o = m_dat;

  assign wbm0_ack_o = own0 && m_ack;
  assign wbm0_err_o = own0 && m_err;
  assign wbm0_dat_o = own0 ? slv_dat : '0;
  assign wbm1_ack_o = own1 && m_ack;
  assign wbm1_err_o = own1 && m_err;
  assign wbm1_dat_o = own1 ? slv_dat : '0;
  assign grant_o    = {own1, own0};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (wbm0_cyc_i && wbm1_cyc_i) begin
          state_d      = last_grant_q ? StOwn0 : StOwn1;
          last_grant_d = !last_grant_q;
        end else if (wbm0_cyc_i) begin
          state_d      = StOwn0;
          last_grant_d = 1'b0;
        end else if (wbm1_cyc_i) begin
          state_d      = StOwn1;
          last_grant_d = 1'b1;
        end
      end
      StOwn0:  if (!wbm0_cyc_i) state_d = StIdle;
      StOwn1:  if (!wbm1_cyc_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // keep: the current owner retains the bus next cycle, so pending errors stay deliverable.
  assign keep  = own_any && m_cyc;
  assign stall = m_stb && !slv_ack && !slv_err && !err_pending_q;

  always_comb begin
    tmo_cnt_d     = 8'd0;
    err_pending_d = 1'b0;
    if (keep && stall) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
    if (keep && m_stb && !err_pending_q &&
        (!hit_any || (stall && tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)))) begin
      err_pending_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Randomized and directed bench for wb_shared_bus_arbiter, compared every cycle against a
// transaction-level reference model of ownership, decode, routing and error rules.
module tb_wb_shared_bus_arbiter;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_cyc[2], m_stb[2], m_we[2];
  logic [3:0]  m_sel[2];
  logic [7:0]  m_adr[2];
  logic [31:0] m_dat[2];
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [3:0]  s_cyc, s_stb, s_sel, s_ack, s_err;
  logic        s_we;
  logic [7:0]  s_adr;
  logic [31:0] s_wdat;
  logic [31:0] s_dat[4];
  logic [127:0] s_dat_flat;
  logic [1:0]  grant;

  assign s_dat_flat = {s_dat[3], s_dat[2], s_dat[1], s_dat[0]};

  wb_shared_bus_arbiter dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm0_cyc_i (m_cyc[0]),
    .wbm0_stb_i (m_stb[0]),
    .wbm0_we_i  (m_we[0]),
    .wbm0_sel_i (m_sel[0]),
    .wbm0_adr_i (m_adr[0]),
    .wbm0_dat_i (m_dat[0]),
    .wbm0_dat_o (m0_rdat),
    .wbm0_ack_o (m0_ack),
    .wbm0_err_o (m0_err),
    .wbm1_cyc_i (m_cyc[1]),
    .wbm1_stb_i (m_stb[1]),
    .wbm1_we_i  (m_we[1]),
    .wbm1_sel_i (m_sel[1]),
    .wbm1_adr_i (m_adr[1]),
    .wbm1_dat_i (m_dat[1]),
    .wbm1_dat_o (m1_rdat),
    .wbm1_ack_o (m1_ack),
    .wbm1_err_o (m1_err),
    .wbs_cyc_o  (s_cyc),
    .wbs_stb_o  (s_stb),
    .wbs_we_o   (s_we),
    .wbs_sel_o  (s_sel),
    .wbs_adr_o  (s_adr),
    .wbs_dat_o  (s_wdat),
    .wbs_dat_i  (s_dat_flat),
    .wbs_ack_i  (s_ack),
    .wbs_err_i  (s_err),
    .grant_o    (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Address map of the default configuration.
  int base[4] = '{8'h00, 8'h09, 8'h10, 8'h20};
  int high[4] = '{8'h08, 8'h09, 8'h1F, 8'h3F};

  // Model state: owner -1 means nobody holds the bus.
  int owner = -1;
  int last  = 1;
  bit pend  = 0;
  int stall = 0;

  logic [1:0]  e_grant;
  logic [3:0]  e_cyc, e_stb, e_resp;
  logic [31:0] e_rd0, e_rd1;
  logic [44:0] e_bus;
  int          e_slave;
  bit          e_slv_resp;

  function automatic int decode(input logic [7:0] a);
    int r = -1;
    for (int i = 0; i < 4; i++) if (r < 0 && int'(a) >= base[i] && int'(a) <= high[i]) r = i;
    return r;
  endfunction

  task automatic model_eval();
    bit          ack, err, o;
    logic [1:0]  si;
    logic [31:0] rd;
    e_grant = '0; e_cyc = '0; e_stb = '0; e_resp = '0;
    e_rd0 = '0; e_rd1 = '0; e_bus = '0;
    e_slave = -1; e_slv_resp = 0;
    ack = 0; err = 0; rd = '0;
    if (!rst && owner >= 0) begin
      o       = 1'(owner);
      e_grant = o ? 2'b10 : 2'b01;
      e_bus   = {m_we[o], m_sel[o], m_adr[o], m_dat[o]};
      e_slave = decode(m_adr[o]);
      if (e_slave >= 0) begin
        si = 2'(e_slave);
        if (m_cyc[o]) e_cyc = 4'b0001 << si;
        if (m_stb[o] && !pend) e_stb = 4'b0001 << si;
        e_slv_resp = s_ack[si] || s_err[si];
        ack = m_stb[o] && s_ack[si];
        err = m_stb[o] && s_err[si];
        rd  = s_dat[si];
      end
      err = (err || pend) && !ack;
      if (!o) begin e_resp[3] = ack; e_resp[2] = err; e_rd0 = rd; end
      else    begin e_resp[1] = ack; e_resp[0] = err; e_rd1 = rd; end
    end
  endtask

  // Applies the clock edge to the model using the inputs seen in model_eval.
  task automatic model_update();
    bit np = 0;
    int ns = 0;
    bit o, waiting;
    if (rst) begin
      owner = -1; last = 1; pend = 0; stall = 0;
      return;
    end
    if (owner >= 0) begin
      o = 1'(owner);
      if (m_cyc[o]) begin
        waiting = m_stb[o] && !pend && !e_slv_resp;
        if (m_stb[o] && !pend && (e_slave < 0 || (waiting && stall == TMO - 1))) np = 1;
        if (waiting) ns = stall + 1;
      end else begin
        owner = -1;
      end
    end else begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
      if (owner >= 0) last = owner;
    end
    pend  = np;
    stall = ns;
  endtask

  task automatic settle();
    #4;
    model_eval();
    check_eq("grant", 64'(grant), 64'(e_grant));
    check_eq("wbs_cyc", 64'(s_cyc), 64'(e_cyc));
    check_eq("wbs_stb", 64'(s_stb), 64'(e_stb));
    check_eq("ack_err", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(e_resp));
    check_eq("m0_dat", 64'(m0_rdat), 64'(e_rd0));
    check_eq("m1_dat", 64'(m1_rdat), 64'(e_rd1));
    check_eq("shared", 64'({s_we, s_sel, s_adr, s_wdat}), 64'(e_bus));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
      m_sel[m] = '0; m_adr[m] = '0; m_dat[m] = '0;
    end
    s_ack = '0; s_err = '0;
    for (int s = 0; s < 4; s++) s_dat[s] = 32'hA5A5_0000 + 32'(s);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset(3);
    check_eq("rst_last_grant_model", 64'(last), 64'd1);

    // m0 write to slave 0
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_sel[0] = 4'hF;
    m_adr[0] = 8'h04; m_dat[0] = 32'hDEAD_BEEF;
    tick();
    settle();
    check_eq("t1_stb", 64'(s_stb), 64'b0001);
    check_eq("t1_grant", 64'(grant), 64'b01);
    advance();
    s_ack[0] = 1;
    settle();
    check_eq("t1_ack", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'b1000);
    check_eq("t1_wdat", 64'(s_wdat), 64'hDEAD_BEEF);
    advance();
    idle_inputs();
    tick(); tick();

    // m1 read from slave 1
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 8'h09; m_sel[1] = 4'hF;
    s_dat[1] = 32'h1234_5678; s_ack[1] = 1;
    tick();
    settle();
    check_eq("t2_stb", 64'(s_stb), 64'b0010);
    check_eq("t2_rdat", 64'(m1_rdat), 64'h1234_5678);
    check_eq("t2_ack", 64'(m1_ack), 64'd1);
    check_eq("t2_m0dat", 64'(m0_rdat), 64'd0);
    advance();
    idle_inputs();
    tick(); tick();

    // Simultaneous requests: round-robin with one idle cycle between owners
    do_reset(1);
    m_cyc[0] = 1; m_cyc[1] = 1;
    tick();
    settle(); check_eq("t3_first", 64'(grant), 64'b01); advance();
    m_cyc[0] = 0;
    tick();
    settle(); check_eq("t3_gap", 64'(grant), 64'b00); advance();
    settle(); check_eq("t3_second", 64'(grant), 64'b10); advance();
    m_cyc[1] = 0;
    tick(); tick();
    m_cyc[0] = 1; m_cyc[1] = 1;
    tick();
    settle(); check_eq("t3_third", 64'(grant), 64'b01); advance();
    idle_inputs();
    tick(); tick();

    // Unmapped address
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 8'hF0;
    tick();
    settle();
    check_eq("t4_nostb", 64'(s_stb), 64'd0);
    check_eq("t4_noerr_yet", 64'(m0_err), 64'd0);
    advance();
    settle(); check_eq("t4_err", 64'(m0_err), 64'd1); advance();
    m_stb[0] = 0;
    settle(); check_eq("t4_err_once", 64'(m0_err), 64'd0); advance();
    idle_inputs();
    tick(); tick();

    // Timeout on a silent slave 2: error on the 17th strobe cycle
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 8'h12;
    tick();
    for (int k = 1; k <= 18; k++) begin
      settle();
      if (k == 16) check_eq("t5_no_err_16", 64'(m0_err), 64'd0);
      if (k == 17) begin
        check_eq("t5_err_17", 64'(m0_err), 64'd1);
        check_eq("t5_stb_masked", 64'(s_stb[2]), 64'd0);
      end
      advance();
    end
    idle_inputs();
    tick(); tick();

    // Ack on the threshold cycle beats the timeout
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 8'h12;
    tick();
    for (int k = 1; k <= 18; k++) begin
      s_ack[2] = (k == 16);
      settle();
      if (k == 16) check_eq("t5b_ack", 64'({m0_ack, m0_err}), 64'b10);
      if (k == 17) check_eq("t5b_no_err", 64'({m0_err, s_stb[2]}), 64'b01);
      advance();
    end
    idle_inputs();
    tick(); tick();

    // Reset during OWN1 mid-strobe
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 8'h20;
    tick(); tick(); tick();
    rst = 1;
    settle();
    check_eq("t6_grant", 64'(grant), 64'd0);
    check_eq("t6_cycstb", 64'({s_cyc, s_stb}), 64'd0);
    check_eq("t6_resp", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
    advance();
    rst = 0;
    m_stb[1] = 0; m_cyc[0] = 1;
    settle(); check_eq("t6_idle", 64'(grant), 64'd0); advance();
    settle(); check_eq("t6_m0_first", 64'(grant), 64'b01); advance();
    idle_inputs();
    tick(); tick();

    // Randomized traffic with alternating responsive and silent slave phases
    for (int n = 0; n < 3000; n++) begin
      bit quiet;
      quiet = ((n / 80) % 3) == 2;
      rst   = ($urandom_range(0, 599) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!m_cyc[m]) m_cyc[m] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, quiet ? 24 : 9) == 0) m_cyc[m] = 0;
        m_stb[m] = m_cyc[m] && (quiet || $urandom_range(0, 3) != 0);
        m_we[m]  = 1'($urandom);
        m_sel[m] = 4'($urandom);
        m_adr[m] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
        m_dat[m] = 32'($urandom);
      end
      for (int s = 0; s < 4; s++) begin
        s_ack[s] = !quiet && ($urandom_range(0, 3) == 0);
        s_err[s] = ($urandom_range(0, quiet ? 199 : 31) == 0);
        s_dat[s] = 32'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus_arbiter.md
Name: wb_shared_bus_arbiter

Overview:
Two-master, N-slave shared Wishbone classic interconnect for the library's slave templates (system block, software registers, BRAM).
- Arbitrates bus ownership round-robin between two masters.
- Decodes the granted master's address against per-slave base/high ranges.
- Routes strobe, data, ack and err between the granted master and the selected slave.
- Generates a bus error for unmapped addresses and for stalled slaves (timeout), so no slave drives a shared net directly.

Parameters:
BUS_DATA_WIDTH, 32, data width (8/16/32/64)
BUS_ADDR_WIDTH, 8, address width
N_SLAVES, 4, number of slave ports (1..8)
SLAVE_BASE_ADDRS, 32'h20_10_09_00, flattened base addresses; slave i at [i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]
SLAVE_HIGH_ADDRS, 32'h3F_1F_09_08, flattened inclusive high addresses, same packing
TIMEOUT_CYCLES, 16, strobe cycles without slave ack/err before forced error (2..255)

Ports:
wb_clk_i  in  1  bus clock
wb_rst_i  in  1  synchronous active-high reset
wbm{0,1}_cyc_i  in  1  master cycle
wbm{0,1}_stb_i  in  1  master strobe
wbm{0,1}_we_i  in  1  master write enable
wbm{0,1}_sel_i  in  BUS_DATA_WIDTH/8  byte enables
wbm{0,1}_adr_i  in  BUS_ADDR_WIDTH  address
wbm{0,1}_dat_i  in  BUS_DATA_WIDTH  write data
wbm{0,1}_dat_o  out  BUS_DATA_WIDTH  read data
wbm{0,1}_ack_o  out  1  acknowledge
wbm{0,1}_err_o  out  1  error
wbs_cyc_o  out  N_SLAVES  per-slave cycle
wbs_stb_o  out  N_SLAVES  per-slave strobe
wbs_we_o  out  1  shared write enable
wbs_sel_o  out  BUS_DATA_WIDTH/8  shared byte enables
wbs_adr_o  out  BUS_ADDR_WIDTH  shared address
wbs_dat_o  out  BUS_DATA_WIDTH  shared write data
wbs_dat_i  in  N_SLAVES*BUS_DATA_WIDTH  flattened slave read data
wbs_ack_i  in  N_SLAVES  slave acks
wbs_err_i  in  N_SLAVES  slave errors
grant_o  out  2  one-hot current owner (debug)

Behaviour:
Clocking and reset
- Single clock wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- During reset: state=IDLE, grant_o=2'b00, last_grant=1 (master 0 wins first), timeout counter=0, err_pending=0.
- During reset, all master ack/err/dat_o and all slave cyc/stb are 0; shared we/sel/adr/dat are 0.
- Reset mid-transfer aborts it: no ack or err is issued to the master.

FSM
- States: IDLE, OWN0, OWN1.
- IDLE: if exactly one cyc_i is high, go to its OWNx. If both are high, grant the master opposite last_grant. Update last_grant on grant.
- OWNx: stay while wbmx_cyc_i=1. When wbmx_cyc_i=0, go to IDLE. This gives one idle cycle minimum between ownerships.
- No pre-emption, regardless of the other master's requests.

Routing (combinational from state; zero added latency)
- Shared we/sel/adr/dat = owner's signals; all 0 in IDLE.
- hit[i] = (adr >= base_i) && (adr <= high_i). With overlapping ranges, the lowest index wins (one-hot sel_slave).
- wbs_cyc_o[i] = owner cyc & sel_slave[i].
- wbs_stb_o[i] = owner stb & sel_slave[i] & ~err_pending.
- Owner ack_o = wbs_ack_i[sel] & owner stb. Owner dat_o = wbs_dat_i slice of sel_slave, or 0 if none.
- Non-owner: ack_o=0, err_o=0, dat_o=0.
- Owner err_o = (wbs_err_i[sel] & stb) | err_pending.

Errors
- Unmapped: owner stb=1 with no hit. err_pending is set next cycle for exactly one cycle, then cleared. The master must drop or re-issue stb.
- Timeout: the counter increments each cycle owner stb=1 and the selected slave gives no ack/err. It clears on ack/err, on stb=0, or on ownership change.
- When the count reaches TIMEOUT_CYCLES-1, err_pending fires on the next cycle. While err_pending=1, slave stb is masked.
- If a slave ack coincides with the timeout threshold, the ack wins and no err is raised.
- ack and err are never both 1 to a master; if both arise, ack takes priority.

Test Plan:
1. Reset 3 cycles, then m0 writes 0xDEADBEEF to adr 0x04 with sel=F. Expect: wbs_stb_o=4'b0001, grant_o=01, and m0 ack follows slave0 ack in the same cycle; m1 ack/err stay 0.
2. m1 reads adr 0x09 while slave1 returns 0x12345678. Expect: wbs_stb_o=4'b0010 and wbm1_dat_o=0x12345678 on ack; wbm0_dat_o=0.
3. Both cyc rise in the same cycle after reset. Expect: m0 granted first. After m0 drops cyc, IDLE for one cycle, then m1 granted. On the next simultaneous request, m0 is granted again.
4. m0 strobes adr 0xF0 (unmapped). Expect: no wbs_stb_o bit set, then wbm0_err_o=1 for exactly one cycle, on the cycle after the strobe.
5. m0 strobes adr 0x12 and slave2 never acks (TIMEOUT_CYCLES=16). Expect: err at the 17th strobe cycle, wbs_stb_o[2] low during the err cycle. A variant with ack on the 16th cycle yields ack and no err.
6. Assert reset during OWN1 mid-strobe. Expect: the next cycle has grant_o=00, all cyc/stb=0, and no ack/err; m0 is granted first afterwards.
